// File: rtl/alu_issue_ctrl.sv
// Request-side issue controller for the ALU: accepts one {op, a, b} request at a time,
// screens the opcode, issues it, waits for completion with a timeout and returns result + status.
module alu_issue_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic [W-1:0] alu_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [1:0]   rsp_err,
    output logic         busy,
    output logic [15:0]  done_cnt
);

    localparam logic [3:0] LAST_OP = 4'b1010;
    localparam int         TW      = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } stateT;

    stateT         state;
    logic [TW-1:0] timer;

    // Gated by reset so nothing is offered while reset is held.
    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= ERR_OK;
            done_cnt  <= '0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_op > LAST_OP) begin
                            // Illegal opcodes never reach the ALU; operand outputs keep their old value.
                            rsp_data  <= '0;
                            rsp_err   <= ERR_ILLEGAL;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_op    <= req_op;
                            alu_a     <= req_a;
                            alu_b     <= req_b;
                            alu_start <= 1'b1;
                            timer     <= '0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the same edge the timer expires still counts as success.
                    if (alu_done) begin
                        rsp_data  <= alu_out;
                        rsp_err   <= ERR_OK;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timer     <= TW'(TIMEOUT);
                        rsp_data  <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (rsp_err == ERR_OK) begin
                            done_cnt <= done_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
